// File: rtl/uart_tx_sched_if.sv
// Bundle between the uart_tx_sched scheduler, its N requesters and the shared transmit engine.
// master: scheduler side (drives grants, engine start and status; reads requests and engine done).
// slave : environment side (requesters plus engine), the mirror image of master.
interface uart_tx_sched_if #(
  parameter int N = 4
);
  logic           en;        // new grants allowed
  logic [N-1:0]   req;       // level request per channel
  logic [8*N-1:0] len;       // frame length per channel, channel i at [8*i+7:8*i]
  logic [N-1:0]   done;      // one-cycle completion pulse on the served channel
  logic           busy;      // scheduler not idle
  logic           err;       // one-cycle watchdog abort pulse
  logic [2:0]     err_ch;    // channel of the most recent abort
  logic [2:0]     sel;       // channel owning the engine
  logic           fs;        // engine frame start
  logic           fd;        // engine frame done
  logic [7:0]     data_len;  // length latched at grant

  modport master (
    input  en, req, len, fd,
    output done, busy, err, err_ch, sel, fs, data_len
  );

  modport slave (
    output en, req, len, fd,
    input  done, busy, err, err_ch, sel, fs, data_len
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one fifo-to-UART transmit engine between N requesters:
// grants a channel, holds fs until the engine reports fd, pulses done, then waits IFG idle
// cycles. A watchdog aborts a frame that stays in SEND for TIMEOUT cycles (0 disables it).
// Ports: clk, rst (async active-high), bus (uart_tx_sched_if.master): en/req/len from the
// requesters, fd from the engine; fs/sel/data_len to the engine; done/busy/err/err_ch status.
module uart_tx_sched #(
  parameter int N       = 4,
  parameter int IFG     = 16,
  parameter int TIMEOUT = 4096,
  parameter int TMO_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_sched_if.master  bus
);

  localparam int PTR_W = $clog2(N);
  localparam int GAP_W = (IFG > 0) ? $clog2(IFG + 1) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG > 0) ? IFG - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_REL,
    S_ABORT,
    S_REL_A,
    S_GAP
  } state_t;

  // One spare bit so ptr + offset can exceed N-1 before the wrap subtraction.
  typedef logic [PTR_W:0] idx_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   sel_q, sel_d;
  logic [7:0]         data_len_q, data_len_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [2:0]         err_ch_q, err_ch_d;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [7:0]         win_len;
  idx_t               scan_idx;
  logic               tmo_hit;
  logic               gap_last;
  logic               done_pulse;
  state_t             after_rel;

  // Winner search: scan from the highest offset down so the last hit is the one closest
  // to ptr, which is the round-robin winner.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = idx_t'(ptr_q) + idx_t'(k);
      if (scan_idx >= idx_t'(N)) begin
        scan_idx = scan_idx - idx_t'(N);
      end
      if (bus.req[scan_idx[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[PTR_W-1:0];
      end
    end
  end

  assign win_len   = bus.len[{win_idx, 3'b000} +: 8];
  assign tmo_hit   = (TIMEOUT != 0) && (wdog_q == TMO_LAST);
  assign gap_last  = (gap_q == GAP_LAST);
  assign after_rel = (IFG == 0) ? S_IDLE : S_GAP;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      data_len_q <= '0;
      wdog_q     <= '0;
      gap_q      <= '0;
      err_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      data_len_q <= data_len_d;
      wdog_q     <= wdog_d;
      gap_q      <= gap_d;
      err_ch_q   <= err_ch_d;
    end
  end

  // Next-state logic. fd wins over the watchdog when both land on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.en && (|bus.req)) state_d = S_ARB;
      S_ARB:   state_d = win_vld ? S_SEND : S_IDLE;
      S_SEND: begin
        if (bus.fd)       state_d = S_REL;
        else if (tmo_hit) state_d = S_ABORT;
      end
      S_REL:   if (!bus.fd) state_d = after_rel;
      S_ABORT: state_d = S_REL_A;
      S_REL_A: if (!bus.fd) state_d = after_rel;
      S_GAP:   if (gap_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: grant latch, watchdog, gap counter, abort channel.
  always_comb begin
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    data_len_d = data_len_q;
    wdog_d     = wdog_q;
    gap_d      = '0;
    err_ch_d   = err_ch_q;
    unique case (state_q)
      S_ARB: begin
        wdog_d = '0;
        if (win_vld) begin
          sel_d      = win_idx;
          data_len_d = win_len;
          ptr_d      = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_SEND: begin
        if (!bus.fd) begin
          if (tmo_hit) begin
            // Captured on entry to ABORT so err_ch is already valid during the err pulse.
            err_ch_d = 3'(sel_q);
          end else if (wdog_q != {TMO_W{1'b1}}) begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end
      S_GAP:   gap_d = gap_q + 1'b1;
      default: ;
    endcase
  end

  // Outputs decoded from state; the REL done pulse fires on the cycle fd is seen low.
  always_comb begin
    done_pulse   = (state_q == S_ABORT) || ((state_q == S_REL) && !bus.fd);
    bus.done     = '0;
    if (done_pulse) begin
      bus.done[sel_q] = 1'b1;
    end
    bus.fs       = (state_q == S_SEND);
    bus.busy     = (state_q != S_IDLE);
    bus.err      = (state_q == S_ABORT);
    bus.err_ch   = err_ch_q;
    bus.sel      = 3'(sel_q);
    bus.data_len = data_len_q;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N(N)) ifa ();
  uart_tx_sched_if #(.N(N)) ifb ();

  uart_tx_sched #(.N(N), .IFG(0), .TIMEOUT(100), .TMO_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  uart_tx_sched #(.N(N), .IFG(16), .TIMEOUT(100), .TMO_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int tests = 0;
  int fails = 0;

  // Engine models: raise fd after dly cycles of fs (0 = never), drop fd once fs falls.
  int dly_a = 0, dly_b = 0;
  int cnt_a = 0, cnt_b = 0;
  bit pfs_a = 1'b0, pfs_b = 1'b0;
  bit rise_a = 1'b0, rise_b = 1'b0;

  // One clock: engine models react 1 time unit after the edge, outputs are read 2 units
  // after the edge, and requesters drop req on seeing their done.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifa.fs) begin
      if (!ifa.fd) begin
        cnt_a++;
        if (dly_a != 0 && cnt_a >= dly_a) ifa.fd = 1'b1;
      end
    end else begin
      ifa.fd = 1'b0;
      cnt_a  = 0;
    end
    if (ifb.fs) begin
      if (!ifb.fd) begin
        cnt_b++;
        if (dly_b != 0 && cnt_b >= dly_b) ifb.fd = 1'b1;
      end
    end else begin
      ifb.fd = 1'b0;
      cnt_b  = 0;
    end
    #1;
    rise_a = ifa.fs && !pfs_a;
    pfs_a  = ifa.fs;
    rise_b = ifb.fs && !pfs_b;
    pfs_b  = ifb.fs;
    for (int i = 0; i < N; i++) begin
      if (ifa.done[i]) ifa.req[i] = 1'b0;
      if (ifb.done[i]) ifb.req[i] = 1'b0;
    end
  endtask

  task automatic wait_rise_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (rise_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rise_b(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (rise_b) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_a(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ifa.done != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_b(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (ifb.done != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ifa.req = '0;
    ifb.req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({ifa.fs, ifa.busy, ifa.err, ifa.done} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl_a: got fs/busy/err/done=%b required 0", {ifa.fs, ifa.busy, ifa.err, ifa.done});
    end
    tests++;
    if ({ifa.sel, ifa.err_ch, ifa.data_len} !== 14'd0) begin
      fails++;
      $display("FAIL reset_data_a: got sel=%0d err_ch=%0d data_len=%0d required 0", ifa.sel, ifa.err_ch, ifa.data_len);
    end
    tests++;
    if ({ifb.fs, ifb.busy, ifb.err, ifb.done} !== 7'd0) begin
      fails++;
      $display("FAIL reset_ctrl_b: got %b required 0", {ifb.fs, ifb.busy, ifb.err, ifb.done});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int n;
    dly_a   = 6;
    ifa.len = {8'd0, 8'd0, 8'd0, 8'd5};
    ifa.en  = 1'b1;
    ifa.req = 4'b0001;
    tick();
    tests++;
    if (ifa.fs !== 1'b0 || ifa.busy !== 1'b1) begin
      fails++;
      $display("FAIL sf_arb: got fs=%b busy=%b required fs=0 busy=1", ifa.fs, ifa.busy);
    end
    tick();
    tests++;
    if (ifa.fs !== 1'b1) begin
      fails++;
      $display("FAIL sf_fs_latency: got fs=%b required 1", ifa.fs);
    end
    tests++;
    if (ifa.sel !== 3'd0 || ifa.data_len !== 8'd5) begin
      fails++;
      $display("FAIL sf_grant: got sel=%0d data_len=%0d required 0 5", ifa.sel, ifa.data_len);
    end
    n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ifa.fs) n++;
      else break;
    end
    tests++;
    if (n != 6) begin
      fails++;
      $display("FAIL sf_fs_cycles: got %0d required 6", n);
    end
    tests++;
    if (ifa.done !== 4'b0001) begin
      fails++;
      $display("FAIL sf_done: got %b required 0001", ifa.done);
    end
    tick();
    tests++;
    if (ifa.done !== 4'b0000 || ifa.busy !== 1'b0) begin
      fails++;
      $display("FAIL sf_after: got done=%b busy=%b required 0000 0", ifa.done, ifa.busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch[6] = '{0, 1, 2, 3, 0, 3};
    bit ok;
    do_reset();
    dly_a   = 3;
    ifa.en  = 1'b1;
    ifa.len = {8'd13, 8'd12, 8'd11, 8'd10};
    ifa.req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        for (int i = 0; i < 20; i++) begin
          if (!ifa.busy) break;
          tick();
        end
        ifa.req = 4'b1001;
      end
      wait_rise_a(60, ok);
      tests++;
      if (!ok || ifa.sel !== 3'(exp_ch[k]) || ifa.data_len !== 8'(10 + exp_ch[k])) begin
        fails++;
        $display("FAIL rr_grant%0d: got started=%b sel=%0d data_len=%0d required sel=%0d data_len=%0d",
                 k, ok, ifa.sel, ifa.data_len, exp_ch[k], 10 + exp_ch[k]);
      end
    end
    wait_done_a(30, ok);
    tests++;
    if (!ok || ifa.done !== 4'b1000) begin
      fails++;
      $display("FAIL rr_last_done: got seen=%b done=%b required 1000", ok, ifa.done);
    end
  endtask

  task automatic test_ifg();
    bit ok;
    int g;
    do_reset();
    dly_b   = 4;
    ifb.en  = 1'b1;
    ifb.len = {8'd0, 8'd0, 8'd9, 8'd8};
    ifb.req = 4'b0011;
    wait_rise_b(10, ok);
    tests++;
    if (!ok || ifb.sel !== 3'd0) begin
      fails++;
      $display("FAIL ifg_first_grant: got started=%b sel=%0d required sel=0", ok, ifb.sel);
    end
    wait_done_b(20, ok);
    tests++;
    if (!ok || ifb.done !== 4'b0001) begin
      fails++;
      $display("FAIL ifg_first_done: got seen=%b done=%b required 0001", ok, ifb.done);
    end
    g = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifb.busy && !ifb.fs) g++;
      else break;
    end
    tests++;
    if (g != 16 || ifb.busy !== 1'b0) begin
      fails++;
      $display("FAIL ifg_gap: got gap=%0d busy_after=%b required gap=16 busy_after=0", g, ifb.busy);
    end
    wait_rise_b(5, ok);
    tests++;
    if (!ok || ifb.sel !== 3'd1 || ifb.data_len !== 8'd9) begin
      fails++;
      $display("FAIL ifg_second_grant: got started=%b sel=%0d len=%0d required sel=1 len=9", ok, ifb.sel, ifb.data_len);
    end
    wait_done_b(20, ok);
    tests++;
    if (!ok || ifb.done !== 4'b0010) begin
      fails++;
      $display("FAIL ifg_second_done: got seen=%b done=%b required 0010", ok, ifb.done);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    do_reset();
    dly_a   = 0;
    ifa.en  = 1'b1;
    ifa.len = {8'd0, 8'd7, 8'd0, 8'd0};
    ifa.req = 4'b0100;
    wait_rise_a(10, ok);
    n = ok ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ifa.fs) n++;
      else break;
    end
    tests++;
    if (n != 100) begin
      fails++;
      $display("FAIL tmo_fs_cycles: got %0d required 100", n);
    end
    tests++;
    if (ifa.err !== 1'b1 || ifa.done !== 4'b0100 || ifa.err_ch !== 3'd2) begin
      fails++;
      $display("FAIL tmo_abort: got err=%b done=%b err_ch=%0d required 1 0100 2", ifa.err, ifa.done, ifa.err_ch);
    end
    tick();
    tests++;
    if (ifa.err !== 1'b0 || ifa.done !== 4'b0000) begin
      fails++;
      $display("FAIL tmo_single_pulse: got err=%b done=%b required 0 0000", ifa.err, ifa.done);
    end
    tick();
    tests++;
    if (ifa.busy !== 1'b0 || ifa.err_ch !== 3'd2) begin
      fails++;
      $display("FAIL tmo_idle: got busy=%b err_ch=%0d required 0 2", ifa.busy, ifa.err_ch);
    end
  endtask

  task automatic test_enable_and_coincide();
    bit ok;
    int n, seen, err_seen;
    do_reset();
    dly_a   = 5;
    ifa.en  = 1'b1;
    ifa.len = {8'd0, 8'd22, 8'd21, 8'd0};
    ifa.req = 4'b0110;
    wait_rise_a(10, ok);
    tests++;
    if (!ok || ifa.sel !== 3'd1) begin
      fails++;
      $display("FAIL en_first_grant: got started=%b sel=%0d required sel=1", ok, ifa.sel);
    end
    ifa.en = 1'b0;
    wait_done_a(20, ok);
    tests++;
    if (!ok || ifa.done !== 4'b0010) begin
      fails++;
      $display("FAIL en_frame_completes: got seen=%b done=%b required 0010", ok, ifa.done);
    end
    dly_a = 100;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.fs || ifa.busy) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL en_parked: got %0d active cycles required 0", seen);
    end
    ifa.en = 1'b1;
    wait_rise_a(5, ok);
    tests++;
    if (!ok || ifa.sel !== 3'd2 || ifa.data_len !== 8'd22) begin
      fails++;
      $display("FAIL en_resume_grant: got started=%b sel=%0d len=%0d required sel=2 len=22", ok, ifa.sel, ifa.data_len);
    end
    n        = 1;
    err_seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ifa.err) err_seen++;
      if (ifa.fs) n++;
      else break;
    end
    tests++;
    if (n != 100 || ifa.done !== 4'b0100 || ifa.err !== 1'b0 || err_seen != 0 || ifa.err_ch !== 3'd0) begin
      fails++;
      $display("FAIL coincide_fd_wins: got fs_cycles=%0d done=%b err=%b err_seen=%0d err_ch=%0d required 100 0100 0 0 0",
               n, ifa.done, ifa.err, err_seen, ifa.err_ch);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    dly_a   = 0;
    ifa.en  = 1'b1;
    ifa.len = {8'd0, 8'd32, 8'd0, 8'd30};
    ifa.req = 4'b0001;
    wait_rise_a(10, ok);
    tick();
    tick();
    tests++;
    if (!ok || ifa.fs !== 1'b1) begin
      fails++;
      $display("FAIL rstm_in_send: got started=%b fs=%b required fs=1", ok, ifa.fs);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({ifa.fs, ifa.done, ifa.err, ifa.busy} !== 7'd0) begin
      fails++;
      $display("FAIL rstm_async: got fs/done/err/busy=%b required 0", {ifa.fs, ifa.done, ifa.err, ifa.busy});
    end
    ifa.req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    dly_a   = 2;
    ifa.req = 4'b0101;
    wait_rise_a(10, ok);
    tests++;
    if (!ok || ifa.sel !== 3'd0 || ifa.data_len !== 8'd30) begin
      fails++;
      $display("FAIL rstm_ptr_cleared: got started=%b sel=%0d len=%0d required sel=0 len=30", ok, ifa.sel, ifa.data_len);
    end
    wait_rise_a(20, ok);
    tests++;
    if (!ok || ifa.sel !== 3'd2 || ifa.data_len !== 8'd32) begin
      fails++;
      $display("FAIL rstm_next_grant: got started=%b sel=%0d len=%0d required sel=2 len=32", ok, ifa.sel, ifa.data_len);
    end
    wait_done_a(20, ok);
  endtask

  initial begin
    rst      = 1'b1;
    ifa.en   = 1'b0;
    ifa.req  = '0;
    ifa.len  = '0;
    ifa.fd   = 1'b0;
    ifb.en   = 1'b0;
    ifb.req  = '0;
    ifb.len  = '0;
    ifb.fd   = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_ifg();
    test_timeout();
    test_enable_and_coincide();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
